// File: rtl/proc_fetch_queue.sv
// ============================================================================
//  Module   : proc_fetch_queue
//  Purpose  : Prefetching instruction-fetch queue between imem and decode,
//             with a flushing redirect for taken branches and jumps.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module proc_fetch_queue #(
    parameter int          DEPTH      = 2,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0200
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         imem_val,
    input  logic                         imem_wait,
    output logic [31:0]                  imem_addr,
    input  logic [31:0]                  imem_rdata,
    output logic                         inst_val,
    input  logic                         inst_rdy,
    output logic [31:0]                  inst,
    output logic [31:0]                  inst_pc,
    input  logic                         redirect_val,
    input  logic [31:0]                  redirect_addr,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int                 c_cnt_w     = $clog2(DEPTH + 1);
    localparam int                 c_ptr_w     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_cnt_w-1:0] c_depth_cnt = c_cnt_w'(DEPTH);
    localparam logic [c_ptr_w-1:0] c_last_ptr  = c_ptr_w'(DEPTH - 1);
    localparam logic [31:0]        c_reset_pc  = RESET_ADDR & ~32'h3;

    generate
        if (DEPTH < 1 || DEPTH > 16) begin : g_depth_check
            $error("proc_fetch_queue: DEPTH must be in 1..16");
        end
    endgenerate

    logic [31:0]        r_fetch_pc;
    logic [c_cnt_w-1:0] r_count;
    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [31:0]        r_mem_pc   [DEPTH];
    logic [31:0]        r_mem_inst [DEPTH];

    logic w_push;
    logic w_pop;

    // Request depends only on registered occupancy and redirect, so decode
    // back-pressure never reaches the memory request path combinationally.
    assign imem_val  = !rst && (r_count < c_depth_cnt) && !redirect_val;
    assign imem_addr = r_fetch_pc;
    assign w_push    = imem_val && !imem_wait;

    assign inst_val  = (r_count != '0);
    assign w_pop     = inst_val && inst_rdy;
    assign inst      = inst_val ? r_mem_inst[r_head] : 32'h0;
    assign inst_pc   = inst_val ? r_mem_pc[r_head]   : 32'h0;
    assign occupancy = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= c_reset_pc;
            r_count    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
        end else if (redirect_val) begin
            // Flush wins over everything; a concurrent pop is simply absorbed.
            r_fetch_pc <= redirect_addr & ~32'h3;
            r_count    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
        end else begin
            if (w_push) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
                r_tail     <= (r_tail == c_last_ptr) ? '0 : r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= (r_head == c_last_ptr) ? '0 : r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage needs no reset: entries are only visible when counted.
    always_ff @(posedge clk) begin
        if (w_push && !redirect_val) begin
            r_mem_pc[r_tail]   <= r_fetch_pc;
            r_mem_inst[r_tail] <= imem_rdata;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_proc_fetch_queue.sv
// ============================================================================
//  Module   : tb_proc_fetch_queue
//  Purpose  : Self-checking bench for proc_fetch_queue at DEPTH 1, 2 and 5.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_proc_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_wait;
    logic        inst_rdy;
    logic        redirect_val;
    logic [31:0] redirect_addr;

    logic        v_imem_val [3];
    logic        v_inst_val [3];
    logic [31:0] v_addr     [3];
    logic [31:0] v_rdata    [3];
    logic [31:0] v_inst     [3];
    logic [31:0] v_pc       [3];
    logic [31:0] v_occ      [3];

    int n_chk  = 0;
    int n_fail = 0;

    int          m_depth [3] = '{1, 2, 5};
    logic [31:0] m_fpc   [3];
    int          m_cnt   [3];
    logic [31:0] m_q     [3][16];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int D = (g == 0) ? 1 : ((g == 1) ? 2 : 5);
        logic [$clog2(D+1)-1:0] occ;
        assign v_rdata[g] = v_addr[g] ^ 32'hA5A5_A5A5;
        assign v_occ[g]   = 32'(occ);
        proc_fetch_queue #(.DEPTH(D), .RESET_ADDR(32'h0000_0200)) u_dut (
            .clk           (clk),
            .rst           (rst),
            .imem_val      (v_imem_val[g]),
            .imem_wait     (imem_wait),
            .imem_addr     (v_addr[g]),
            .imem_rdata    (v_rdata[g]),
            .inst_val      (v_inst_val[g]),
            .inst_rdy      (inst_rdy),
            .inst          (v_inst[g]),
            .inst_pc       (v_pc[g]),
            .redirect_val  (redirect_val),
            .redirect_addr (redirect_addr),
            .occupancy     (occ)
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int g = 0; g < 3; g++) begin
            m_cnt[g] = 0;
            m_fpc[g] = 32'h200;
        end
    endtask

    // Reference queue: list with the oldest entry at index 0.
    task automatic model_step();
        for (int g = 0; g < 3; g++) begin
            bit ev, push, pop;
            string p;
            p    = $sformatf("d%0d", m_depth[g]);
            ev   = !redirect_val && (m_cnt[g] < m_depth[g]);
            push = ev && !imem_wait;
            pop  = (m_cnt[g] != 0) && inst_rdy;
            chk({p, " imem_val"},  32'(v_imem_val[g]), 32'(ev));
            chk({p, " imem_addr"}, v_addr[g], m_fpc[g]);
            chk({p, " inst_val"},  32'(v_inst_val[g]), 32'(m_cnt[g] != 0));
            chk({p, " occupancy"}, v_occ[g], 32'(m_cnt[g]));
            if (m_cnt[g] != 0) begin
                chk({p, " inst_pc"}, v_pc[g], m_q[g][0]);
                chk({p, " inst"},    v_inst[g], m_q[g][0] ^ 32'hA5A5_A5A5);
            end
            if (redirect_val) begin
                m_cnt[g] = 0;
                m_fpc[g] = redirect_addr & ~32'h3;
            end else begin
                if (pop) begin
                    for (int i = 0; i < 15; i++) m_q[g][i] = m_q[g][i+1];
                    m_cnt[g]--;
                end
                if (push) begin
                    m_q[g][m_cnt[g]] = m_fpc[g];
                    m_cnt[g]++;
                    m_fpc[g] = m_fpc[g] + 32'd4;
                end
            end
        end
    endtask

    task automatic cycle(input logic w, input logic r, input logic rv, input logic [31:0] ra);
        @(negedge clk);
        rst           = 1'b0;
        imem_wait     = w;
        inst_rdy      = r;
        redirect_val  = rv;
        redirect_addr = ra;
        #1;
        model_step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int g = 0; g < 3; g++) begin
            chk("rst imem_val",  32'(v_imem_val[g]), 32'h0);
            chk("rst inst_val",  32'(v_inst_val[g]), 32'h0);
            chk("rst inst",      v_inst[g], 32'h0);
            chk("rst inst_pc",   v_pc[g], 32'h0);
            chk("rst occupancy", v_occ[g], 32'h0);
        end
        model_reset();
    endtask

    typedef struct {
        logic        w, r, rv;
        logic [31:0] ra;
        logic        ev;
        logic [31:0] ea;
        logic        eiv;
        logic [31:0] epc;
        int          eocc;
    } vec_t;

    vec_t tv [16];

    initial begin
        // Hand-derived expectations for the DEPTH=2 instance.
        tv[0]  = '{0, 0, 0, 32'h0,         1, 32'h200,       0, 32'h0,         0};
        tv[1]  = '{0, 0, 0, 32'h0,         1, 32'h204,       1, 32'h200,       1};
        tv[2]  = '{0, 0, 0, 32'h0,         0, 32'h208,       1, 32'h200,       2};
        tv[3]  = '{0, 0, 0, 32'h0,         0, 32'h208,       1, 32'h200,       2};
        tv[4]  = '{0, 1, 0, 32'h0,         0, 32'h208,       1, 32'h200,       2};
        tv[5]  = '{0, 1, 0, 32'h0,         1, 32'h208,       1, 32'h204,       1};
        tv[6]  = '{1, 0, 0, 32'h0,         1, 32'h20C,       1, 32'h208,       1};
        tv[7]  = '{1, 0, 0, 32'h0,         1, 32'h20C,       1, 32'h208,       1};
        tv[8]  = '{0, 0, 0, 32'h0,         1, 32'h20C,       1, 32'h208,       1};
        tv[9]  = '{0, 1, 1, 32'h1003,      0, 32'h210,       1, 32'h208,       2};
        tv[10] = '{0, 1, 0, 32'h0,         1, 32'h1000,      0, 32'h0,         0};
        tv[11] = '{0, 1, 0, 32'h0,         1, 32'h1004,      1, 32'h1000,      1};
        tv[12] = '{0, 0, 1, 32'hFFFFFFFC,  0, 32'h1008,      1, 32'h1004,      1};
        tv[13] = '{0, 0, 0, 32'h0,         1, 32'hFFFFFFFC,  0, 32'h0,         0};
        tv[14] = '{0, 1, 0, 32'h0,         1, 32'h0,         1, 32'hFFFFFFFC,  1};
        tv[15] = '{0, 1, 0, 32'h0,         1, 32'h4,         1, 32'h0,         1};

        rst = 1'b1; imem_wait = 1'b0; inst_rdy = 1'b0;
        redirect_val = 1'b0; redirect_addr = 32'h0;
        do_reset();

        for (int i = 0; i < 16; i++) begin
            cycle(tv[i].w, tv[i].r, tv[i].rv, tv[i].ra);
            chk($sformatf("vec%0d imem_val", i),  32'(v_imem_val[1]), 32'(tv[i].ev));
            chk($sformatf("vec%0d imem_addr", i), v_addr[1], tv[i].ea);
            chk($sformatf("vec%0d inst_val", i),  32'(v_inst_val[1]), 32'(tv[i].eiv));
            chk($sformatf("vec%0d occupancy", i), v_occ[1], 32'(tv[i].eocc));
            if (tv[i].eiv)
                chk($sformatf("vec%0d inst_pc", i), v_pc[1], tv[i].epc);
        end

        // Fill, then reset asynchronously with entries held.
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 32'h0);
        chk("prefill occupancy d2", v_occ[1], 32'd2);
        do_reset();
        cycle(0, 1, 0, 32'h0);
        chk("post-rst imem_addr", v_addr[1], 32'h200);
        chk("post-rst inst_val",  32'(v_inst_val[1]), 32'h0);
        cycle(0, 1, 0, 32'h0);
        chk("post-rst inst_pc",   v_pc[1], 32'h200);

        // Back-to-back redirects: the last one wins.
        cycle(0, 1, 1, 32'h3000);
        cycle(0, 1, 1, 32'h4002);
        cycle(0, 1, 0, 32'h0);
        chk("last redirect wins", v_addr[1], 32'h4000);

        for (int n = 0; n < 1500; n++) begin
            logic [31:0] ra;
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                ra = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                                 : $urandom;
                cycle($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 6,
                      $urandom_range(0, 24) == 0, ra);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/proc_fetch_queue.md
Name: proc_fetch_queue

Overview:
- Parametrised instruction-fetch front end for the TinyRV1 processors.
- Successor to the single-cycle fetch path. Instead of one fetch per executed instruction, it prefetches up to DEPTH instructions into a FIFO.
- It decouples imem_wait stalls from the decode stage and supports a redirect that flushes the queue on taken branches and jumps.
- Sits between the imem port and the decode stage of the multicycle and pipelined processor tops.

Parameters:
- DEPTH, 2, number of queue entries; legal range 1..16, any integer.
- RESET_ADDR, 32'h00000200, first fetch address after reset.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- imem_val  output  1  fetch request valid
- imem_wait  input  1  memory not ready; request not accepted this cycle
- imem_addr  output  32  fetch address (always word aligned)
- imem_rdata  input  32  instruction; valid in the cycle imem_val && !imem_wait
- inst_val  output  1  queue head valid
- inst_rdy  input  1  decode accepts head
- inst  output  32  head instruction
- inst_pc  output  32  head instruction address
- redirect_val  input  1  flush queue and restart fetch
- redirect_addr  input  32  new fetch address; bits [1:0] ignored
- occupancy  output  $clog2(DEPTH+1)  current entry count (debug/perf)

Behaviour:
- **Clock and reset:** one clock, clk. Reset is asynchronous and active-high on rst.
- **Reset state (immediate on rst high, held while high):**
  - fetch_pc = RESET_ADDR & ~3; count = 0; head/tail pointers = 0.
  - imem_val = 0, inst_val = 0, inst = 0, inst_pc = 0, occupancy = 0.
- **Reset mid-operation:** all entries are discarded with no partial handshake. Fetch resumes at RESET_ADDR on the first clk edge after rst deasserts.
- **Fetch request:**
  - imem_val = !rst && (count < DEPTH) && !redirect_val.
  - imem_val depends only on registered count and redirect_val, never on inst_rdy.
  - imem_addr = fetch_pc, held stable while imem_wait is high.
- **Push:** fires when imem_val && !imem_wait.
  - Writes {fetch_pc, imem_rdata} at tail; tail advances, wrapping at DEPTH.
  - fetch_pc += 4, 32-bit wrap (0xFFFFFFFC -> 0x00000000).
- **Pop:** fires when inst_val && inst_rdy.
  - Head advances, wrapping at DEPTH.
  - inst_val = (count != 0). inst and inst_pc are registered entry contents, i.e. combinational reads of the FIFO array at head.
  - When empty, inst and inst_pc are don't-care; the bench checks them only when inst_val = 1.
- **Push and pop in the same cycle:** count unchanged, both pointers advance.
  - When full, no push can occur (imem_val = 0), so a pop frees the entry for the next cycle. There is no combinational full bypass.
- **Latency:**
  - Empty queue to inst_val: 1 cycle after an accepted fetch. No same-cycle bypass from imem_rdata to inst.
  - Steady-state throughput: 1 instruction/cycle when imem_wait = 0 and inst_rdy = 1.
- **Redirect (highest priority):**
  - At the edge where redirect_val = 1: count = 0, head = tail = 0, fetch_pc = {redirect_addr[31:2], 2'b00}.
  - No fetch is issued that cycle (imem_val forced 0).
  - A pop in the same cycle still completes, i.e. decode consumes the current head. All other entries, including ones that would have been pushed, are discarded.
  - Back-to-back redirects: the last one wins.
  - The first fetch at the new address is issued the cycle after redirect_val drops.
- **Wait handling:** any number of consecutive imem_wait cycles. While imem_wait is high, no state changes except pops and redirects.
- **occupancy:** equals count, range 0..DEPTH; updated at the same edge as push, pop and flush.
- **Illegal:** DEPTH = 0 (elaboration error via static check).

Test Plan:
1. Reset, imem_wait = 0, inst_rdy = 1, DEPTH = 2, memory returns addr^0xA5A5A5A5 → imem_addr sequence 0x200, 0x204, 0x208…; inst_val first high the cycle after the first accept, with inst_pc = 0x200; one instruction per cycle thereafter.
2. inst_rdy = 0 for 6 cycles → exactly DEPTH pushes (0x200, 0x204), then imem_val = 0 and occupancy = 2. Raise inst_rdy → in-order pops with 0x200 first, and refill resumes at 0x208 one cycle after the first pop.
3. imem_wait high for 3 cycles at addr 0x208 → imem_addr held at 0x208 with no push; push occurs on the cycle wait drops; no duplicate or skipped PCs.
4. Queue full, redirect_val = 1 with redirect_addr = 0x1003 while inst_rdy = 1 → head 0x200 consumed; next cycle occupancy = 0 and imem_addr = 0x1000; next inst_pc seen is 0x1000.
5. redirect_addr = 0xFFFFFFFC → fetches 0xFFFFFFFC then 0x00000000; inst_pc values match.
6. Assert rst for 1 cycle mid-stream with occupancy = 2 → outputs are zero immediately (asynchronous). After release, the first fetch is at 0x200 and no stale entries appear. Repeat scenarios 1–4 with DEPTH = 1 and DEPTH = 5 (non-power-of-2 wrap).
